// File: rtl/thumb_fetch_pkg.sv
// Shared fetch-side definitions: fetch FSM states and the Thumb-2 32-bit
// instruction prefixes (top five bits of the first halfword).
package thumb_fetch_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    localparam logic [4:0] PFX32_A = 5'b11101;
    localparam logic [4:0] PFX32_B = 5'b11110;
    localparam logic [4:0] PFX32_C = 5'b11111;

    function automatic logic is_32bit(input logic [15:0] hw);
        return (hw[15:11] == PFX32_A) || (hw[15:11] == PFX32_B) || (hw[15:11] == PFX32_C);
    endfunction

endpackage

// File: rtl/thumb_prefetch_queue_hw_queue.sv
// Halfword circular buffer: up to two pushes and two pops per cycle, flush clears.
// Latency: pushed entries visible at hw0/hw1 the cycle after the push; no bypass.
// Backpressure: none internally; the caller never pushes beyond free space.
module hw_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               push_cnt,
    input  logic [15:0]              push_lo,
    input  logic [15:0]              push_hi,
    input  logic [1:0]               pop_cnt,
    output logic [15:0]              hw0,
    output logic [15:0]              hw1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage needs no reset: count gates what is ever considered valid.
    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) begin
            mem[wr_ptr] <= push_lo;
        end
        if (push_cnt == 2'd2) begin
            mem[wr_ptr + PTR_W'(1)] <= push_hi;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            count  <= count + OCC_W'(push_cnt) - OCC_W'(pop_cnt);
        end
    end

    assign hw0 = mem[rd_ptr];
    assign hw1 = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/thumb_prefetch_queue.sv
// Thumb prefetch queue: word ROM fetch into a halfword queue, 16/32-bit decode split; PREFETCH_PERF_EN adds stall/flush counters.
// Latency: first inst_valid two cycles after its rom_req (response pushed, no bypass).
// Backpressure: inst_ready=0 holds the head stable; fetch stops once free space < 2 halfwords.
module thumb_prefetch_queue
    import thumb_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    output logic                   rom_req,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [31:0]            rom_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_data,
    output logic                   inst_is32,
    output logic [ADDR_W-1:0]      inst_pc,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0]            stall_cnt,
    output logic [15:0]            flush_cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic [ADDR_W-1:0] pc_q;
    logic              inflight_q;
    logic              skip_q;

    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    need;
    logic              space_ok;
    logic [15:0]       hw0;
    logic [15:0]       hw1;
    logic              hw0_is32;
    logic              fire;
    logic              resp_ok;
    logic [1:0]        push_cnt;
    logic [1:0]        pop_cnt;
    logic [15:0]       push_lo;
    logic              unused_pc_bit;

    assign unused_pc_bit = redirect_pc[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fetch_en)  state_d = ST_RUN;
            ST_RUN:  if (!fetch_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // An outstanding request already owns two halfwords of free space.
    assign need     = (OCC_W+1)'(occ) + (inflight_q ? (OCC_W+1)'(4) : (OCC_W+1)'(2));
    assign space_ok = need <= (OCC_W+1)'(DEPTH);
    assign rom_req  = (state_q == ST_RUN) && space_ok && !redirect_valid;
    assign rom_addr = fetch_addr_q;

    assign hw0_is32   = is_32bit(hw0);
    assign inst_valid = hw0_is32 ? (occ >= OCC_W'(2)) : (occ >= OCC_W'(1));
    assign fire       = inst_valid && inst_ready;
    assign pop_cnt    = fire ? (hw0_is32 ? 2'd2 : 2'd1) : 2'd0;

    // A redirect in the response cycle kills that response.
    assign resp_ok  = inflight_q && !redirect_valid;
    assign push_cnt = !resp_ok ? 2'd0 : (skip_q ? 2'd1 : 2'd2);
    assign push_lo  = skip_q ? rom_rdata[31:16] : rom_rdata[15:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_addr_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
            pc_q         <= {RESET_PC[ADDR_W-1:1], 1'b0};
            inflight_q   <= 1'b0;
            skip_q       <= RESET_PC[1];
        end else begin
            inflight_q <= rom_req;
            if (redirect_valid) begin
                fetch_addr_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
                pc_q         <= {redirect_pc[ADDR_W-1:1], 1'b0};
                skip_q       <= redirect_pc[1];
            end else begin
                if (rom_req) begin
                    fetch_addr_q <= fetch_addr_q + ADDR_W'(4);
                end
                if (fire) begin
                    pc_q <= pc_q + (hw0_is32 ? ADDR_W'(4) : ADDR_W'(2));
                end
                if (resp_ok) begin
                    skip_q <= 1'b0;
                end
            end
        end
    end

    hw_queue #(
        .DEPTH (DEPTH)
    ) u_hw_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push_cnt (push_cnt),
        .push_lo  (push_lo),
        .push_hi  (rom_rdata[31:16]),
        .pop_cnt  (pop_cnt),
        .hw0      (hw0),
        .hw1      (hw1),
        .count    (occ)
    );

    assign inst_data = hw0_is32 ? {hw0, hw1} : {16'h0000, hw0};
    assign inst_is32 = hw0_is32;
    assign inst_pc   = pc_q;
    assign occupancy = occ;

`ifdef PREFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (inst_ready && !inst_valid && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (redirect_valid && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_thumb_prefetch_queue.sv
// Directed bench for thumb_prefetch_queue: expected instructions queued per test,
// an independent negedge monitor pops and compares each accepted instruction.
module tb_thumb_prefetch_queue;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic        inst_is32;
    logic [15:0] inst_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [2:0]  occupancy;
`ifdef PREFETCH_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] data;
        logic        is32;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rom [64];
    int          checks = 0;
    int          errors = 0;

    thumb_prefetch_queue #(
        .ADDR_W   (16),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .rom_req        (rom_req),
        .rom_addr       (rom_addr),
        .rom_rdata      (rom_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_is32      (inst_is32),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .occupancy      (occupancy)
`ifdef PREFETCH_PERF_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // ROM: request seen mid-cycle, word presented for the whole following cycle.
    initial begin
        logic        r;
        logic [15:0] a;
        rom_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            r = rom_req;
            a = rom_addr;
            @(posedge clk);
            #1;
            rom_rdata = r ? rom[a[7:2]] : 32'hDEAD_BEEF;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_inst", {15'd0, inst_is32, inst_pc, inst_data}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("inst", {15'd0, inst_is32, inst_pc, inst_data}, {15'd0, e.is32, e.pc, e.data});
                end
            end
        end
    end

    task automatic expect_inst(input logic [15:0] pc, input logic [31:0] data, input logic is32);
        exp_t e;
        e.pc   = pc;
        e.data = data;
        e.is32 = is32;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("drained", 64'(exp_q.size()), 64'd0);
        inst_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int req_at;
        int vld_at;
        logic seen;
        rst            = 1'b0;
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_inst_valid", 64'(inst_valid), 64'd0);
        check("reset_occupancy",  64'(occupancy),  64'd0);
        check("reset_rom_req",    64'(rom_req),    64'd0);
        check("reset_rom_addr",   64'(rom_addr),   64'h0000);

        // Four 16-bit instructions, first-valid latency
        do_reset();
        rom[0] = 32'h1840_2001;
        rom[1] = 32'h46C0_4770;
        expect_inst(16'h0000, 32'h0000_2001, 1'b0);
        expect_inst(16'h0002, 32'h0000_1840, 1'b0);
        expect_inst(16'h0004, 32'h0000_4770, 1'b0);
        expect_inst(16'h0006, 32'h0000_46C0, 1'b0);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        req_at = -1;
        vld_at = -1;
        for (int c = 0; c < 20 && vld_at < 0; c++) begin
            @(negedge clk);
            if (rom_req && req_at < 0) req_at = c;
            if (inst_valid) vld_at = c;
        end
        check("first_valid_latency", 64'(vld_at - req_at), 64'd2);
        wait_drain(40);

        // 32-bit instruction straddling a word boundary
        do_reset();
        rom[0] = 32'hF000_2001;
        rom[1] = 32'h1234_F800;
        expect_inst(16'h0000, 32'h0000_2001, 1'b0);
        expect_inst(16'h0002, 32'hF000_F800, 1'b1);
        expect_inst(16'h0006, 32'h0000_1234, 1'b0);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        wait_drain(40);

        // Backpressure: queue fills, fetch stops, nothing lost
        do_reset();
        rom[0] = 32'h0002_0001;
        rom[1] = 32'h0004_0003;
        rom[2] = 32'h0006_0005;
        rom[3] = 32'h0008_0007;
        for (int i = 0; i < 8; i++) expect_inst(16'(2 * i), 32'(i + 1), 1'b0);
        fetch_en = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("full_occupancy", 64'(occupancy), 64'd4);
        check("full_rom_req",   64'(rom_req),   64'd0);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        wait_drain(60);

        // Redirect to 0x0006 while the word at 0 is in flight
        do_reset();
        rom[0] = 32'h0222_0111;
        rom[1] = 32'h0BBB_0AAA;
        rom[2] = 32'h0DDD_0CCC;
        expect_inst(16'h0006, 32'h0000_0BBB, 1'b0);
        expect_inst(16'h0008, 32'h0000_0CCC, 1'b0);
        expect_inst(16'h000A, 32'h0000_0DDD, 1'b0);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = rom_req;
        end
        check("redir_first_req_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0006;
        @(negedge clk);
        check("redir_cycle_no_req", 64'(rom_req), 64'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_next_req",  64'(rom_req),  64'd1);
        check("redir_next_addr", 64'(rom_addr), 64'h0004);
        wait_drain(40);

        // Asynchronous reset mid-stream, then refetch from RESET_PC
        do_reset();
        rom[0] = 32'h0002_0001;
        rom[1] = 32'h0004_0003;
        fetch_en = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_inst_valid", 64'(inst_valid), 64'd0);
        check("arst_occupancy",  64'(occupancy),  64'd0);
        check("arst_rom_req",    64'(rom_req),    64'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) expect_inst(16'(2 * i), 32'(i + 1), 1'b0);
        rst        = 1'b1;
        inst_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = rom_req;
        end
        check("arst_refetch_req",  64'(seen),     64'd1);
        check("arst_refetch_addr", 64'(rom_addr), 64'h0000);
        wait_drain(40);

`ifdef PREFETCH_PERF_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            redirect_valid = 1'b1;
            redirect_pc    = 16'h0010;
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        inst_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        inst_ready = 1'b0;
        @(negedge clk);
        check("perf_flush_cnt", 64'(flush_cnt), 64'd3);
        check("perf_stall_cnt", 64'(stall_cnt), 64'd5);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thumb_prefetch_queue.md
THUMB_PREFETCH_QUEUE -- requirements
Module: thumb_prefetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning byte-address width of program space.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue capacity in halfwords (power of 2, >=4).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch byte address (bit0 ignored).
REQ-004 SHALL have ports, clock and reset first:
 clk  input  1  rising-edge clock
 rst  input  1  reset; one clock; reset is asynchronous and active-low
 fetch_en  input  1  1 = issue ROM fetches
 rom_req  output  1  ROM read request
 rom_addr  output  ADDR_W  word-aligned byte address ([1:0]=0)
 rom_rdata  input  32  read word, valid exactly 1 cycle after rom_req; [15:0] = halfword at addr+0
 inst_valid  output  1  instruction available
 inst_ready  input  1  decode accepts
 inst_data  output  32  16-bit: {16'h0, hw0}; 32-bit: {hw0, hw1}
 inst_is32  output  1  instruction is 32-bit
 inst_pc  output  ADDR_W  byte address of hw0
 redirect_valid  input  1  branch/flush request
 redirect_pc  input  ADDR_W  new target (bit0 ignored)
 occupancy  output  $clog2(DEPTH)+1  halfwords queued

Function
REQ-005 SHALL classify hw0 as 32-bit iff hw0[15:11] is 5'b11101, 5'b11110 or 5'b11111.
REQ-006 SHALL assert inst_valid iff occupancy>=1 and hw0 is 16-bit, or occupancy>=2 and hw0 is 32-bit.
REQ-007 SHALL pop 1 (16-bit) or 2 (32-bit) halfwords on inst_valid&&inst_ready; inst_pc advances by 2 or 4.
REQ-008 SHALL hold inst_data/inst_is32/inst_pc stable while inst_valid&&!inst_ready.
REQ-009 SHALL assert rom_req only in state RUN when DEPTH - occupancy - 2*inflight >= 2 and no redirect this cycle; inflight is 1 in the cycle after rom_req.
REQ-010 SHALL push the response halfwords at the end of the cycle rom_rdata is valid; no bypass: first inst_valid is 2 cycles after its rom_req.
REQ-011 SHALL support push and pop in the same cycle; occupancy never exceeds DEPTH nor underflows.
REQ-012 SHALL implement states IDLE (no requests) and RUN; IDLE->RUN when fetch_en=1, RUN->IDLE when fetch_en=0; queue drains in IDLE.
REQ-013 SHALL on redirect_valid: complete any handshake in that cycle, flush queue, discard in-flight response, set fetch address to redirect_pc with [1:0]=0, next-cycle rom_req (if RUN).
REQ-014 SHALL, when target bit1=1 (redirect or RESET_PC), drop the lower halfword of the first returned word.
REQ-015 SHALL wrap the fetch address modulo 2^ADDR_W.

Reset
REQ-016 SHALL, while rst=0, asynchronously force: state IDLE, rom_req=0, rom_addr=RESET_PC&~3, inst_valid=0, occupancy=0, inflight=0, skip flag=RESET_PC[1].
REQ-017 SHALL discard any response whose request preceded reset assertion.

Configuration
REQ-018 SHALL, when PREFETCH_PERF_EN is defined, add outputs stall_cnt[15:0] (cycles inst_ready=1&&inst_valid=0) and flush_cnt[15:0] (redirects), both saturating, reset to 0.
REQ-019 SHALL, without PREFETCH_PERF_EN, have neither those ports nor counter logic.

Structure
REQ-020 SHALL place the fetch state enum and the 32-bit prefix constants in a shared package thumb_fetch_pkg.
REQ-021 SHALL instantiate one sub-module hw_queue (parametrised halfword circular buffer, push up to 2, pop up to 2, flush).

Verification
REQ-022 ROM words 0x18402001,0x46C04770, fetch_en=1, ready=1 -> inst_pc 0,2,4,6; data 0x2001,0x1840,0x4770,0x46C0; is32=0; first valid 2 cycles after first rom_req.
REQ-023 Word@0 = 0xF0002001, word@4 = 0x1234F800 -> inst 0x2001 pc 0; then 0xF000F800 is32=1 pc 2; then 0x1234 pc 6.
REQ-024 ready=0 for 12 cycles -> occupancy saturates at DEPTH, rom_req low, no data lost; ready=1 -> in-order resume.
REQ-025 redirect_pc=0x0006 while a response is in flight -> response dropped, next rom_addr=0x0004, first inst_pc=0x0006.
REQ-026 rst low mid-stream, asynchronously -> inst_valid=0, occupancy=0, rom_req=0 before next edge; release -> refetch from RESET_PC.
REQ-027 PREFETCH_PERF_EN defined, 3 redirects, 5 starved cycles -> flush_cnt=3, stall_cnt=5.
